// File: rtl/barrel_shift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter/rotator.
// Includes the register-placement arithmetic used by the top to map mux levels onto pipeline stages.
package barrel_shift_pkg;

    typedef enum logic [1:0] {
        SH_ROT = 2'b00,
        SH_LSH = 2'b01,
        SH_ASH = 2'b10,
        SH_RSV = 2'b11
    } shift_mode_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    localparam int MAX_VEC_W = 1024;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MAX_VEC_W-1:0] reverse_vec(input logic [MAX_VEC_W-1:0] v, input int w);
        logic [MAX_VEC_W-1:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[i] = v[w-1-i];
        end
        return r;
    endfunction

    function automatic int stage_last_level(input int s, input int dist_w, input int stages);
        return ((s + 1) * dist_w) / stages - 1;
    endfunction

    function automatic int level_stage(input int k, input int dist_w, input int stages);
        for (int s = 0; s < stages; s++) begin
            if (stage_last_level(s, dist_w, stages) >= k) begin
                return s;
            end
        end
        return stages - 1;
    endfunction

endpackage

// File: rtl/barrel_shift_level.sv
// One mux level of the right-shift core: moves the data right by SHIFT when en is set,
// filling from the wrapped bits (rotate) or from the fill bit, and reports the OR of discarded bits.
module barrel_shift_level #(
    parameter int WIDTH     = 16,
    parameter int SHIFT     = 1,
    parameter bit STICKY_EN = 1'b0
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             fill,
    input  logic             rotate,
    input  logic             en,
    output logic [WIDTH-1:0] data_out,
    output logic             shifted_or
);

    logic [WIDTH-1:0] shifted;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i + SHIFT < WIDTH) begin : g_move
            assign shifted[i] = data_in[i + SHIFT];
        end else begin : g_wrap
            assign shifted[i] = rotate ? data_in[i + SHIFT - WIDTH] : fill;
        end
    end

    assign data_out = en ? shifted : data_in;

    if (STICKY_EN) begin : g_sticky
        assign shifted_or = en && !rotate && (|data_in[SHIFT-1:0]);
    end else begin : g_no_sticky
        assign shifted_or = 1'b0;
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined, valid/ready handshaked barrel shifter/rotator built around a right-shift core.
// Define BARREL_SHIFT_PIPE_STICKY_EN to compute the sticky (discarded-bits OR) output; otherwise sticky is 0.
module barrel_shift_pipe
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIST_WIDTH = $clog2(WIDTH),
    parameter int STAGES     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      din,
    input  logic [DIST_WIDTH-1:0] distance,
    input  logic                  dir,
    input  shift_mode_e           mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      dout,
    output logic                  sticky
);

`ifdef BARREL_SHIFT_PIPE_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("barrel_shift_pipe: WIDTH must be a power of 2 and >= 2");
    end
    if (WIDTH >= MAX_VEC_W) begin : g_too_wide
        $error("barrel_shift_pipe: WIDTH exceeds reverse_vec capacity");
    end
    if (DIST_WIDTH != $clog2(WIDTH)) begin : g_bad_dist
        $error("barrel_shift_pipe: DIST_WIDTH must equal clog2(WIDTH)");
    end
    if (STAGES < 1 || STAGES > DIST_WIDTH) begin : g_bad_stages
        $error("barrel_shift_pipe: STAGES must be in 1..DIST_WIDTH");
    end

    // Per-stage source (input port or previous register) and the registers themselves.
    logic [WIDTH-1:0]      src_data   [STAGES];
    logic                  src_fill   [STAGES];
    logic                  src_rot    [STAGES];
    logic                  src_dir    [STAGES];
    logic [DIST_WIDTH-1:0] src_dist   [STAGES];
    logic                  src_sticky [STAGES];
    logic                  src_valid  [STAGES];

    logic [WIDTH-1:0]      st_data    [STAGES];
    logic                  st_fill    [STAGES];
    logic                  st_rot     [STAGES];
    logic                  st_dir     [STAGES];
    logic [DIST_WIDTH-1:0] st_dist    [STAGES];
    logic                  st_sticky  [STAGES];
    logic                  st_valid   [STAGES];

    logic [WIDTH-1:0]      res_data   [STAGES];
    logic                  res_sticky [STAGES];
    logic [STAGES-1:0]     load;

    logic [MAX_VEC_W-1:0]  din_rev_full;
    logic                  unused_din_rev;

    assign din_rev_full   = reverse_vec(MAX_VEC_W'(din), WIDTH);
    assign unused_din_rev = ^din_rev_full[MAX_VEC_W-1:WIDTH];

    // Left operations enter the core reversed; arithmetic fill only applies to right shifts.
    always_comb begin
        src_data[0]   = (dir == DIR_LEFT) ? din_rev_full[WIDTH-1:0] : din;
        src_fill[0]   = (mode == SH_ASH) && (dir == DIR_RIGHT) && din[WIDTH-1];
        src_rot[0]    = (mode == SH_ROT);
        src_dir[0]    = dir;
        src_dist[0]   = distance;
        src_sticky[0] = 1'b0;
        src_valid[0]  = in_valid;
        for (int s = 1; s < STAGES; s++) begin
            src_data[s]   = st_data[s-1];
            src_fill[s]   = st_fill[s-1];
            src_rot[s]    = st_rot[s-1];
            src_dir[s]    = st_dir[s-1];
            src_dist[s]   = st_dist[s-1];
            src_sticky[s] = st_sticky[s-1];
            src_valid[s]  = st_valid[s-1];
        end
    end

    for (genvar k = 0; k < DIST_WIDTH; k++) begin : g_lvl
        localparam int STG   = level_stage(k, DIST_WIDTH, STAGES);
        localparam bit FIRST = (STG == 0) ? (k == 0)
                                          : (k == stage_last_level(STG - 1, DIST_WIDTH, STAGES) + 1);
        logic [WIDTH-1:0] d_in;
        logic [WIDTH-1:0] d_out;
        logic             acc_in;
        logic             acc_out;
        logic             lost;

        if (FIRST) begin : g_first
            assign d_in   = src_data[STG];
            assign acc_in = src_sticky[STG];
        end else begin : g_chain
            assign d_in   = g_lvl[k-1].d_out;
            assign acc_in = g_lvl[k-1].acc_out;
        end

        barrel_shift_level #(
            .WIDTH     (WIDTH),
            .SHIFT     (1 << k),
            .STICKY_EN (STICKY_EN)
        ) u_level (
            .data_in    (d_in),
            .fill       (src_fill[STG]),
            .rotate     (src_rot[STG]),
            .en         (src_dist[STG][k]),
            .data_out   (d_out),
            .shifted_or (lost)
        );

        assign acc_out = acc_in | lost;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_res
        localparam int LAST = stage_last_level(s, DIST_WIDTH, STAGES);
        assign res_sticky[s] = g_lvl[LAST].acc_out;
        if (s == STAGES - 1) begin : g_out
            logic [MAX_VEC_W-1:0] rev_full;
            logic                 unused_rev;
            assign rev_full    = reverse_vec(MAX_VEC_W'(g_lvl[LAST].d_out), WIDTH);
            assign unused_rev  = ^rev_full[MAX_VEC_W-1:WIDTH];
            assign res_data[s] = (src_dir[s] == DIR_LEFT) ? rev_full[WIDTH-1:0] : g_lvl[LAST].d_out;
        end else begin : g_mid
            assign res_data[s] = g_lvl[LAST].d_out;
        end
    end

    // A stage advances when it is empty or its successor is advancing this cycle.
    always_comb begin
        load = '0;
        load[STAGES-1] = !st_valid[STAGES-1] || out_ready;
        for (int s = STAGES - 2; s >= 0; s--) begin
            load[s] = !st_valid[s] || load[s+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                st_valid[s]  <= 1'b0;
                st_data[s]   <= '0;
                st_fill[s]   <= 1'b0;
                st_rot[s]    <= 1'b0;
                st_dir[s]    <= 1'b0;
                st_dist[s]   <= '0;
                st_sticky[s] <= 1'b0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (load[s]) begin
                    st_valid[s] <= src_valid[s];
                    if (src_valid[s]) begin
                        st_data[s]   <= res_data[s];
                        st_sticky[s] <= res_sticky[s];
                        st_fill[s]   <= src_fill[s];
                        st_rot[s]    <= src_rot[s];
                        st_dir[s]    <= src_dir[s];
                        st_dist[s]   <= src_dist[s];
                    end
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = st_valid[STAGES-1];
    assign dout      = st_data[STAGES-1];
    assign sticky    = st_sticky[STAGES-1];

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench: three shifters (STAGES = 1, 2, 4) checked against an arithmetic reference model.
// Sticky expectations follow BARREL_SHIFT_PIPE_STICKY_EN.
module tb_barrel_shift_pipe;
    import barrel_shift_pkg::*;

    localparam int W  = 16;
    localparam int NI = 3;

`ifdef BARREL_SHIFT_PIPE_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    // Directed cases: din, distance, dir, mode, expected dout, expected sticky.
    localparam int ND = 7;
    localparam logic [15:0] D_DIN  [ND] = '{16'h1234, 16'h8001, 16'h8001, 16'h8000, 16'h00FF, 16'hA5C3, 16'hC001};
    localparam int          D_DIST [ND] = '{4, 1, 1, 15, 4, 0, 2};
    localparam logic        D_DIR  [ND] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam int          D_MODE [ND] = '{0, 0, 1, 2, 1, 2, 2};
    localparam logic [15:0] D_EXP  [ND] = '{16'h4123, 16'h0003, 16'h0002, 16'hFFFF, 16'h000F, 16'hA5C3, 16'h0004};
    localparam logic        D_STK  [ND] = '{1'b0, 1'b0, STK, 1'b0, STK, 1'b0, STK};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        in_valid  [NI];
    logic        in_ready  [NI];
    logic [W-1:0] din      [NI];
    logic [3:0]  distance  [NI];
    logic        dir       [NI];
    shift_mode_e mode      [NI];
    logic        out_valid [NI];
    logic        out_ready [NI];
    logic [W-1:0] dout     [NI];
    logic        sticky    [NI];

    int checks = 0;
    int errors = 0;
    logic [16:0] sb_q [$];

    always #5 clk = ~clk;

    function automatic int stages_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        barrel_shift_pipe #(
            .WIDTH  (W),
            .STAGES (stages_of(g))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .din       (din[g]),
            .distance  (distance[g]),
            .dir       (dir[g]),
            .mode      (mode[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .dout      (dout[g]),
            .sticky    (sticky[g])
        );
    end

    // Reference: returns {sticky, result} from plain shift arithmetic on a 32-bit copy.
    function automatic logic [16:0] model(input logic [15:0] x, input int d, input logic left, input int m);
        logic [31:0]        w;
        logic signed [15:0] sx;
        logic [15:0]        r;
        logic               s;
        w  = {16'h0000, x};
        sx = x;
        if (m == 0) begin
            r = left ? 16'((w << d) | (w >> (16 - d))) : 16'((w >> d) | (w << (16 - d)));
            s = 1'b0;
        end else if (m == 2 && !left) begin
            r = sx >>> d;
            s = |(w & ((32'h1 << d) - 32'h1));
        end else if (left) begin
            r = 16'(w << d);
            s = |(w >> (16 - d));
        end else begin
            r = 16'(w >> d);
            s = |(w & ((32'h1 << d) - 32'h1));
        end
        if (!STK) s = 1'b0;
        return {s, r};
    endfunction

    task automatic idle_inputs();
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            din[i]       = '0;
            distance[i]  = '0;
            dir[i]       = 1'b0;
            mode[i]      = SH_ROT;
            out_ready[i] = 1'b1;
        end
    endtask

    task automatic drive_random(input int i);
        din[i]      = W'($urandom);
        distance[i] = 4'($urandom_range(0, 15));
        dir[i]      = 1'($urandom_range(0, 1));
        mode[i]     = shift_mode_e'($urandom_range(0, 3));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            checks += 3;
            if (out_valid[i] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_out_valid[%0d]: got %b expected 0", i, out_valid[i]);
            end
            if (dout[i] !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL reset_dout[%0d]: got %h expected 0000", i, dout[i]);
            end
            if (sticky[i] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_sticky[%0d]: got %b expected 0", i, sticky[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (in_ready[i] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_in_ready[%0d]: got %b expected 1", i, in_ready[i]);
            end
        end
    endtask

    task automatic test_directed();
        int lat;
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < ND; c++) begin
                @(posedge clk);
                #1;
                out_ready[i] = 1'b1;
                in_valid[i]  = 1'b1;
                din[i]       = D_DIN[c];
                distance[i]  = 4'(D_DIST[c]);
                dir[i]       = D_DIR[c];
                mode[i]      = shift_mode_e'(D_MODE[c]);
                @(negedge clk);
                checks++;
                if (in_ready[i] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL directed_in_ready[%0d] case %0d: got %b expected 1", i, c, in_ready[i]);
                end
                @(posedge clk);
                #1;
                in_valid[i] = 1'b0;
                lat = 1;
                while (out_valid[i] !== 1'b1 && lat < 20) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                checks += 3;
                if (lat != stages_of(i)) begin
                    errors++;
                    $display("[TB] FAIL directed_latency[%0d] case %0d: got %0d expected %0d", i, c, lat, stages_of(i));
                end
                if (dout[i] !== D_EXP[c]) begin
                    errors++;
                    $display("[TB] FAIL directed_dout[%0d] case %0d: got %h expected %h", i, c, dout[i], D_EXP[c]);
                end
                if (sticky[i] !== D_STK[c]) begin
                    errors++;
                    $display("[TB] FAIL directed_sticky[%0d] case %0d: got %b expected %b", i, c, sticky[i], D_STK[c]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int          i;
        int          pushed;
        int          popped;
        logic [16:0] exp;
        logic [15:0] it_din  [8];
        int          it_dist [8];
        logic        it_dir  [8];
        int          it_mode [8];
        i = 2;
        for (int k = 0; k < 8; k++) begin
            it_din[k]  = 16'($urandom);
            it_dist[k] = $urandom_range(0, 15);
            it_dir[k]  = 1'($urandom_range(0, 1));
            it_mode[k] = $urandom_range(0, 3);
        end
        sb_q.delete();
        pushed = 0;
        popped = 0;
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 60 && popped < 8; cyc++) begin
            out_ready[i] = (cyc >= 7);
            in_valid[i]  = (pushed < 8);
            if (pushed < 8) begin
                din[i]      = it_din[pushed];
                distance[i] = 4'(it_dist[pushed]);
                dir[i]      = it_dir[pushed];
                mode[i]     = shift_mode_e'(it_mode[pushed]);
            end
            @(negedge clk);
            if (cyc >= 4 && cyc < 7) begin
                checks += 3;
                if (in_ready[i] !== 1'b0 || pushed != 4) begin
                    errors++;
                    $display("[TB] FAIL b2b_full cyc %0d: in_ready=%b accepted=%0d expected 0 and 4", cyc, in_ready[i], pushed);
                end
                if (out_valid[i] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_stall_valid cyc %0d: got %b expected 1", cyc, out_valid[i]);
                end
                if (sb_q.size() == 0 || {sticky[i], dout[i]} !== sb_q[0]) begin
                    errors++;
                    $display("[TB] FAIL b2b_stall_hold cyc %0d: got %h expected %h", cyc, {sticky[i], dout[i]},
                             (sb_q.size() == 0) ? 17'h0 : sb_q[0]);
                end
            end
            if (in_valid[i] && in_ready[i]) begin
                sb_q.push_back(model(din[i], int'(distance[i]), dir[i], int'(mode[i])));
                pushed++;
            end
            if (out_valid[i] && out_ready[i]) begin
                checks++;
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 17'h0;
                if ({sticky[i], dout[i]} !== exp) begin
                    errors++;
                    $display("[TB] FAIL b2b_order item %0d: got %h expected %h", popped, {sticky[i], dout[i]}, exp);
                end
                popped++;
            end
            @(posedge clk);
            #1;
        end
        in_valid[i]  = 1'b0;
        out_ready[i] = 1'b1;
        checks++;
        if (pushed != 8 || popped != 8 || sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_count: accepted=%0d delivered=%0d expected 8 and 8", pushed, popped);
        end
    endtask

    task automatic test_reset_midstream();
        logic [16:0] exp  [NI];
        logic        seen [NI];
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            out_ready[i] = 1'b0;
            in_valid[i]  = 1'b1;
            drive_random(i);
        end
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            in_valid[i] = 1'b0;
            checks++;
            if (out_valid[i] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL midreset_pre_valid[%0d]: got %b expected 1", i, out_valid[i]);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks += 2;
            if (out_valid[i] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_out_valid[%0d]: got %b expected 0", i, out_valid[i]);
            end
            if (dout[i] !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL midreset_dout[%0d]: got %h expected 0000", i, dout[i]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            out_ready[i] = 1'b1;
            in_valid[i]  = 1'b1;
            drive_random(i);
            exp[i]  = model(din[i], int'(distance[i]), dir[i], int'(mode[i]));
            seen[i] = 1'b0;
            checks++;
            if (in_ready[i] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL midreset_in_ready[%0d]: got %b expected 1", i, in_ready[i]);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) in_valid[i] = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            for (int i = 0; i < NI; i++) begin
                if (out_valid[i] === 1'b1 && !seen[i]) begin
                    seen[i] = 1'b1;
                    checks++;
                    if ({sticky[i], dout[i]} !== exp[i]) begin
                        errors++;
                        $display("[TB] FAIL midreset_first[%0d]: got %h expected %h", i, {sticky[i], dout[i]}, exp[i]);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < NI; i++) begin
            if (!seen[i]) begin
                checks++;
                errors++;
                $display("[TB] FAIL midreset_timeout[%0d]: got no output expected one", i);
            end
        end
    endtask

    task automatic test_random(input int i);
        int          tp_acc;
        int          tp_pop;
        logic [16:0] exp;
        sb_q.delete();
        @(posedge clk);
        #1;
        // Random valid/ready traffic, then a bounded drain.
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc >= 300 && sb_q.size() == 0) break;
            in_valid[i]  = (cyc < 300) && ($urandom_range(0, 99) < 70);
            out_ready[i] = (cyc >= 300) || ($urandom_range(0, 99) < 70);
            drive_random(i);
            @(negedge clk);
            if (in_valid[i] && in_ready[i]) begin
                sb_q.push_back(model(din[i], int'(distance[i]), dir[i], int'(mode[i])));
            end
            if (out_valid[i] && out_ready[i]) begin
                checks++;
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 17'h0;
                if ({sticky[i], dout[i]} !== exp) begin
                    errors++;
                    $display("[TB] FAIL random_result[%0d] cyc %0d: got %h expected %h", i, cyc, {sticky[i], dout[i]}, exp);
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid[i] = 1'b0;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL random_drain[%0d]: %0d results outstanding expected 0", i, sb_q.size());
            sb_q.delete();
        end
        tp_acc = 0;
        tp_pop = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            in_valid[i]  = (cyc < 40);
            out_ready[i] = 1'b1;
            drive_random(i);
            @(negedge clk);
            if (in_valid[i] && in_ready[i]) begin
                sb_q.push_back(model(din[i], int'(distance[i]), dir[i], int'(mode[i])));
                tp_acc++;
            end
            if (out_valid[i] && out_ready[i]) begin
                if (cyc < 40) tp_pop++;
                checks++;
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 17'h0;
                if ({sticky[i], dout[i]} !== exp) begin
                    errors++;
                    $display("[TB] FAIL stream_result[%0d] cyc %0d: got %h expected %h", i, cyc, {sticky[i], dout[i]}, exp);
                end
            end
            @(posedge clk);
            #1;
        end
        checks += 3;
        if (tp_acc != 40) begin
            errors++;
            $display("[TB] FAIL throughput_in[%0d]: got %0d accepts expected 40", i, tp_acc);
        end
        if (tp_pop != 40 - stages_of(i)) begin
            errors++;
            $display("[TB] FAIL throughput_out[%0d]: got %0d results expected %0d", i, tp_pop, 40 - stages_of(i));
        end
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL stream_drain[%0d]: %0d results outstanding expected 0", i, sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        for (int i = 0; i < NI; i++) test_random(i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
